// File: rtl/adc_unpack_pkg.sv
// Shared widths, pad mask and buffer-occupancy states for the ADC word unpacker.
// No logic of its own; lane_sample() is a pure combinational slice helper.
// Imported by the interface, the word buffer and the unpacker top.
package adc_pkg;

  localparam int LANES    = 4;
  localparam int LANE_W   = 16;
  localparam int SAMPLE_W = 14;
  localparam int WORD_W   = 64;
  localparam logic [WORD_W-1:0] PAD_MASK = 64'hC000_C000_C000_C000;

  // Occupancy of the two-entry word buffer: nothing, cur only, cur and nxt.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Low SAMPLE_W bits of lane 'lane'; the two pad bits above each lane are dropped.
  function automatic logic [SAMPLE_W-1:0] lane_sample(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        lane);
    return word[LANE_W*int'(lane) +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/adc_unpack_if.sv
// Word-in / sample-out handshake bundle of the ADC unpacker.
// Pure wiring, no latency.
// Both directions use valid/ready; a transfer needs both high at the clock edge.
interface adc_unpack_if;
  import adc_pkg::*;

  logic [WORD_W-1:0]   i_word;
  logic                i_word_valid;
  logic                o_word_ready;
  logic [SAMPLE_W-1:0] o_sample;
  logic                o_sample_valid;
  logic                i_sample_ready;
  logic [1:0]          o_lane;
  logic                o_pad_err;

  // Producer of words and consumer of samples.
  modport master (
    output i_word, i_word_valid, i_sample_ready,
    input  o_word_ready, o_sample, o_sample_valid, o_lane, o_pad_err
  );

  // The unpacker itself.
  modport slave (
    input  i_word, i_word_valid, i_sample_ready,
    output o_word_ready, o_sample, o_sample_valid, o_lane, o_pad_err
  );

endinterface

// File: rtl/adc_word_skid.sv
// Two-entry word buffer: cur (being emitted) and nxt (waiting behind it).
// Latency: a word into an empty buffer is on out_dat one cycle after acceptance.
// Backpressure: in_rdy = !nxt valid, registered only; out_rdy retires cur, nxt slides up the same edge.
module adc_word_skid
  import adc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [WORD_W-1:0] in_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [WORD_W-1:0] out_dat
);

  skid_state_e       state_q, state_d;
  logic [WORD_W-1:0] cur_q, cur_d;
  logic [WORD_W-1:0] nxt_q, nxt_d;
  logic              cur_vld, nxt_vld;
  logic              push, pop;

  // The occupancy state is the pair of valid bits for cur and nxt.
  assign cur_vld = (state_q != EMPTY);
  assign nxt_vld = (state_q == TWO);
  assign in_rdy  = !nxt_vld;
  assign push    = in_vld && in_rdy;
  assign pop     = cur_vld && out_rdy;
  assign out_vld = cur_vld;
  assign out_dat = cur_q;

  // Next-state and data steering: a retiring cur is refilled from nxt first, else from the input.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          cur_d   = in_dat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          cur_d = in_dat;
        end else if (push) begin
          nxt_d   = in_dat;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_rdy is low here, so push cannot coincide; kept general for safety.
        if (pop) begin
          cur_d   = nxt_q;
          state_d = push ? TWO : ONE;
          if (push) begin
            nxt_d = in_dat;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Buffer registers; reset drops both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cur_q   <= '0;
      nxt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
    end
  end

endmodule

// File: rtl/adc_unpack.sv
// Unpacks 64-bit words of four padded 14-bit ADC lanes into one sample per transfer, lanes 0..3.
// Latency: lane 0 appears one cycle after the word is accepted into an empty buffer; one sample/cycle sustained.
// Backpressure: outputs hold while i_sample_ready is low; o_word_ready drops only when a second word is waiting.
module adc_unpack
  import adc_pkg::*;
(
  input  logic         i_62clk,
  input  logic         i_nreset,
  adc_unpack_if.slave  bus
);

  logic [WORD_W-1:0] cur_dat;
  logic              cur_vld;
  logic              sample_xfer;
  logic              word_done;
  logic              word_acc;
  logic [1:0]        lane_q, lane_d;
  logic              pad_err_q, pad_err_d;

  assign sample_xfer = cur_vld && bus.i_sample_ready;
  assign word_done   = sample_xfer && (lane_q == 2'(LANES - 1));
  assign word_acc    = bus.i_word_valid && bus.o_word_ready;

  adc_word_skid u_skid (
    .clk     (i_62clk),
    .rst_n   (i_nreset),
    .in_vld  (bus.i_word_valid),
    .in_rdy  (bus.o_word_ready),
    .in_dat  (bus.i_word),
    .out_vld (cur_vld),
    .out_rdy (word_done),
    .out_dat (cur_dat)
  );

  // Lane advances per sample transfer and wraps to 0 as the word retires; pad error is sticky.
  always_comb begin
    lane_d    = lane_q;
    pad_err_d = pad_err_q;
    if (sample_xfer) begin
      lane_d = lane_q + 2'd1;
    end
    if (word_acc && ((bus.i_word & PAD_MASK) != '0)) begin
      pad_err_d = 1'b1;
    end
  end

  // Lane counter and sticky pad flag.
  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      lane_q    <= 2'd0;
      pad_err_q <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      pad_err_q <= pad_err_d;
    end
  end

  assign bus.o_sample       = lane_sample(cur_dat, lane_q);
  assign bus.o_lane         = lane_q;
  assign bus.o_sample_valid = cur_vld;
  assign bus.o_pad_err      = pad_err_q;

endmodule

// File: tb/tb_adc_unpack.sv
// Directed bench for adc_unpack with a scoreboard: accepted words push hand-computed lane samples,
// a negedge monitor pops and compares on every sample transfer.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_adc_unpack;
  import adc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_unpack_if bus ();

  adc_unpack dut (
    .i_62clk  (clk),
    .i_nreset (rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic [13:0] s;
    logic [1:0]  l;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_vec = 0;

  logic [63:0] vec_w [0:7] = '{
    64'h0001_03E8_0001_03E8,
    64'h0004_0003_0002_0001,
    64'h0008_0007_0006_0005,
    64'h000C_000B_000A_0009,
    64'h4000_0000_0000_0005,
    64'h3FFF_2AAA_1555_0123,
    64'h1111_2222_3333_0ABC,
    64'h0100_0200_0300_0400
  };

  // Expected samples per vector, lane 0 first, pads removed by hand.
  logic [13:0] vec_s [0:7][0:3] = '{
    '{14'h03E8, 14'h0001, 14'h03E8, 14'h0001},
    '{14'h0001, 14'h0002, 14'h0003, 14'h0004},
    '{14'h0005, 14'h0006, 14'h0007, 14'h0008},
    '{14'h0009, 14'h000A, 14'h000B, 14'h000C},
    '{14'h0005, 14'h0000, 14'h0000, 14'h0000},
    '{14'h0123, 14'h1555, 14'h2AAA, 14'h3FFF},
    '{14'h0ABC, 14'h3333, 14'h2222, 14'h1111},
    '{14'h0400, 14'h0300, 14'h0200, 14'h0100}
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare transfers first, then record words accepted on the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_sample_valid && bus.i_sample_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got sample %0h lane %0d, expected no sample", bus.o_sample, bus.o_lane);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_sample", 64'(bus.o_sample), 64'(sb_e.s));
          chk("sb_lane", 64'(bus.o_lane), 64'(sb_e.l));
        end
      end
      if (bus.i_word_valid && bus.o_word_ready) begin
        for (int k = 0; k < 4; k++) begin
          sb_e.s = vec_s[cur_vec][k];
          sb_e.l = 2'(k);
          exp_q.push_back(sb_e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int v);
    cur_vec          = v;
    bus.i_word       = vec_w[v];
    bus.i_word_valid = 1'b1;
  endtask

  task automatic idle();
    bus.i_word_valid = 1'b0;
    bus.i_word       = '0;
  endtask

  // Offer a vector and return 1ns after the edge that accepts it.
  task automatic send(input int v, input string name);
    int n;
    n = 0;
    offer(v);
    @(negedge clk);
    while (!bus.o_word_ready && n < 30) begin
      cyc();
      @(negedge clk);
      n++;
    end
    if (!bus.o_word_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: word not accepted within 30 cycles, ready %0b required 1", name, bus.o_word_ready);
    end
    cyc();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.i_sample_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sample", 64'(bus.o_sample), 0);
    chk("rst_valid", 64'(bus.o_sample_valid), 0);
    chk("rst_lane", 64'(bus.o_lane), 0);
    chk("rst_pad_err", 64'(bus.o_pad_err), 0);
    chk("rst_word_ready", 64'(bus.o_word_ready), 1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single word: first sample one cycle after accept, lanes in order
    bus.i_sample_ready = 1'b1;
    send(0, "t1_accept");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("t1_latency_valid", 64'(bus.o_sample_valid), 1);
        chk("t1_first_sample", 64'(bus.o_sample), 64'h3E8);
      end
      chk("t1_lane_order", 64'(bus.o_lane), 64'(k));
      cyc();
    end
    @(negedge clk);
    chk("t1_drained", 64'(bus.o_sample_valid), 0);
    chk("t1_pad_err", 64'(bus.o_pad_err), 0);
    cyc();

    // Back-to-back words every 4 cycles: 12 contiguous samples
    for (int c = 0; c <= 12; c++) begin
      if ((c % 4) == 0 && c < 12) begin
        offer(5 + c / 4);
        @(negedge clk);
        chk("t2_word_ready", 64'(bus.o_word_ready), 1);
      end else begin
        idle();
        @(negedge clk);
      end
      if (c >= 1) chk("t2_no_gap", 64'(bus.o_sample_valid), 1);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t2_drained", 64'(bus.o_sample_valid), 0);
    cyc();

    // Backpressure after lane 1, B buffered, C held off until A lane 3 transfers
    offer(1);
    @(negedge clk);
    cyc();
    idle();
    @(negedge clk);
    cyc();
    bus.i_sample_ready = 1'b0;
    offer(2);
    @(negedge clk);
    chk("t3_b_accept", 64'(bus.o_word_ready), 1);
    chk("t3_hold_sample", 64'(bus.o_sample), 64'h2);
    chk("t3_hold_lane", 64'(bus.o_lane), 1);
    cyc();
    offer(3);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("t3_hold_sample", 64'(bus.o_sample), 64'h2);
      chk("t3_hold_lane", 64'(bus.o_lane), 1);
      chk("t3_hold_valid", 64'(bus.o_sample_valid), 1);
      chk("t3_ready_low", 64'(bus.o_word_ready), 0);
      cyc();
    end
    bus.i_sample_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t3_c_blocked", 64'(bus.o_word_ready), 0);
      chk("t3_drain_lane", 64'(bus.o_lane), 64'(s + 1));
      cyc();
    end
    @(negedge clk);
    chk("t3_c_ready", 64'(bus.o_word_ready), 1);
    chk("t3_b_lane0", 64'(bus.o_sample), 64'h5);
    cyc();
    idle();
    repeat (8) cyc();
    @(negedge clk);
    chk("t3_drained", 64'(bus.o_sample_valid), 0);

    // Pad error: sticky across later clean words
    chk("t4_pad_before", 64'(bus.o_pad_err), 0);
    cyc();
    send(4, "t4_accept");
    @(negedge clk);
    chk("t4_pad_set", 64'(bus.o_pad_err), 1);
    chk("t4_lane0", 64'(bus.o_sample), 64'h5);
    repeat (4) cyc();
    send(0, "t4_clean");
    repeat (5) cyc();
    @(negedge clk);
    chk("t4_pad_sticky", 64'(bus.o_pad_err), 1);
    cyc();

    // Lane 3 transfer and accept in the same cycle, nxt empty
    send(0, "t5a_first");
    repeat (3) cyc();
    offer(7);
    @(negedge clk);
    chk("t5a_lane3", 64'(bus.o_lane), 3);
    chk("t5a_ready", 64'(bus.o_word_ready), 1);
    cyc();
    idle();
    @(negedge clk);
    chk("t5a_new_lane0", 64'(bus.o_lane), 0);
    chk("t5a_new_sample", 64'(bus.o_sample), 64'h400);
    repeat (4) cyc();

    // Lane 3 transfer with nxt full: nxt shown, pending word buffered next
    send(5, "t5b_cur");
    offer(6);
    @(negedge clk);
    cyc();
    offer(7);
    repeat (2) cyc();
    @(negedge clk);
    chk("t5b_lane3", 64'(bus.o_lane), 3);
    chk("t5b_full", 64'(bus.o_word_ready), 0);
    cyc();
    @(negedge clk);
    chk("t5b_nxt_lane0", 64'(bus.o_lane), 0);
    chk("t5b_nxt_sample", 64'(bus.o_sample), 64'hABC);
    chk("t5b_ready_again", 64'(bus.o_word_ready), 1);
    cyc();
    idle();
    @(negedge clk);
    chk("t5b_buffered", 64'(bus.o_word_ready), 0);
    chk("t5b_lane1", 64'(bus.o_lane), 1);
    repeat (8) cyc();
    @(negedge clk);
    chk("t5b_drained", 64'(bus.o_sample_valid), 0);
    cyc();

    // Reset mid-word with B buffered; C must come out clean afterwards
    send(1, "t6_a");
    offer(2);
    @(negedge clk);
    cyc();
    idle();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.o_sample_valid), 0);
    chk("t6_rst_sample", 64'(bus.o_sample), 0);
    chk("t6_rst_lane", 64'(bus.o_lane), 0);
    chk("t6_rst_ready", 64'(bus.o_word_ready), 1);
    chk("t6_rst_pad_err", 64'(bus.o_pad_err), 0);
    exp_q.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    send(6, "t6_c");
    @(negedge clk);
    chk("t6_c_valid", 64'(bus.o_sample_valid), 1);
    chk("t6_c_lane0", 64'(bus.o_lane), 0);
    chk("t6_c_sample", 64'(bus.o_sample), 64'hABC);
    repeat (4) cyc();
    @(negedge clk);
    chk("t6_drained", 64'(bus.o_sample_valid), 0);
    chk("sb_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_unpack.md
ADC_UNPACK -- requirements
Module: adc_unpack

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: i_62clk input, i_nreset input; all other ports are synchronous to i_62clk.
REQ-002 i_62clk  input  1  system sample clock; all state updates on its rising edge.
REQ-003 i_nreset  input  1  asynchronous active-low reset.
REQ-004 i_word  input  64  packed word; four lanes, lane k at bits [16k+13:16k], pad bits [16k+15:16k+14].
REQ-005 i_word_valid  input  1  i_word is valid this cycle.
REQ-006 o_word_ready  output  1  block accepts i_word this cycle; transfer occurs when i_word_valid and o_word_ready are both high.
REQ-007 o_sample  output  14  unpacked sample.
REQ-008 o_sample_valid  output  1  o_sample is valid this cycle.
REQ-009 i_sample_ready  input  1  sink accepts o_sample this cycle; transfer occurs when o_sample_valid and i_sample_ready are both high.
REQ-010 o_lane  output  2  lane index of the current o_sample.
REQ-011 o_pad_err  output  1  sticky flag; set when an accepted word has any nonzero pad bit.

Function
REQ-012 Storage SHALL be two word registers: cur (word being emitted, with a 2-bit lane counter) and nxt (buffered word), each with its own valid bit.
REQ-013 o_word_ready SHALL equal !nxt_valid; it SHALL NOT depend combinationally on i_word_valid or i_sample_ready.
REQ-014 An accepted word SHALL load cur when cur is empty, or when cur is completing lane 3 this cycle and nxt is empty; otherwise it SHALL load nxt.
REQ-015 When cur completes lane 3 and nxt is valid, nxt SHALL move to cur at lane 0 in the same cycle; a word accepted in that same cycle SHALL load nxt.
REQ-016 Output SHALL be registered in the cur path: o_sample = cur[16*lane+13 : 16*lane], o_lane = lane, o_sample_valid = cur_valid.
REQ-017 Latency SHALL be one cycle: a word accepted at rising edge N SHALL present lane 0 with o_sample_valid high after edge N (cycle N+1) when cur was empty.
REQ-018 Lanes SHALL be emitted in order 0, 1, 2, 3; the lane counter SHALL advance only on a sample transfer and SHALL wrap from 3 to 0.
REQ-019 Sustained throughput SHALL be one sample per cycle: back-to-back words with i_sample_ready held high SHALL produce no bubble.
REQ-020 When i_sample_ready is low, o_sample, o_lane and o_sample_valid SHALL hold stable.
REQ-021 Pad bits SHALL be discarded from o_sample.
REQ-022 o_pad_err SHALL be set on the edge that accepts a word where (i_word & 64'hC000_C000_C000_C000) != 0, and SHALL clear only on reset.
REQ-023 States are EMPTY (cur and nxt empty), ONE (cur only) and TWO (cur and nxt). Transitions: EMPTY->ONE on accept; ONE->TWO on accept without cur completing; ONE->EMPTY on lane 3 transfer without accept; TWO->ONE on lane 3 transfer; all other cases hold.

Reset
REQ-024 Reset SHALL drive o_sample=0, o_sample_valid=0, o_lane=0, o_pad_err=0 and o_word_ready=1, and SHALL clear cur_valid, nxt_valid and the lane counter.
REQ-025 Reset asserted mid-word SHALL discard the remaining lanes and any buffered word; after release, the first output sample SHALL be lane 0 of the next accepted word.

Structure
REQ-026 Package adc_pkg SHALL hold LANES=4, LANE_W=16, SAMPLE_W=14, WORD_W=64, PAD_MASK=64'hC000_C000_C000_C000 and the 3-state enum (EMPTY, ONE, TWO).
REQ-027 The two-entry word buffer SHALL be a sub-module adc_word_skid (valid/ready in, valid/ready out); lane selection and pad checking SHALL stay in adc_unpack.

Verification
REQ-028 Single word: reset, accept i_word=64'h0001_03E8_0001_03E8 with i_sample_ready=1 -> samples 0x3E8, 0x001, 0x3E8, 0x001 on consecutive cycles, o_lane 0..3, first sample at accept+1, o_pad_err=0.
REQ-029 Back-to-back: three words offered every 4 cycles with i_sample_ready=1 -> 12 contiguous samples with no gap; o_word_ready never low for more than 1 cycle.
REQ-030 Backpressure: i_sample_ready=0 for 5 cycles after lane 1 -> o_sample and o_lane=1 held; o_word_ready falls after a second word is buffered; third word not accepted until lane 3 transfers.
REQ-031 Pad error: accept 64'h4000_0000_0000_0005 -> o_pad_err=1 from the next cycle, samples 0x005, 0, 0, 0; it stays set across later clean words.
REQ-032 Reset mid-word: assert i_nreset low after lane 1 of word A while word B is buffered -> all outputs return to reset values asynchronously; after release, accepting word C yields C lane 0 first with no residue from A or B.
REQ-033 Simultaneous events: lane 3 transfer and new word accept in the same cycle, with nxt empty -> next cycle shows the new word's lane 0; with nxt full -> nxt lane 0 is shown and the new word is buffered.
